minihls_kernel_arbiter: RTL and testbench

- Shares one generated minihls kernel instance among N_REQ requesters.
- Kernel handshake: kernel starts on ready, asserts valid with result on out, returns to idle on accept.
- Arbiter picks one requester round-robin, launches the kernel, captures the result and returns it, tagged, to the winning requester.
- Sits between the top-level command logic and a single kernel instance.

---
 rtl/minihls_arb_pkg.sv | 21 ++
 rtl/minihls_rr_pick.sv | 38 +++
 rtl/minihls_kernel_arbiter.sv | 158 +++++++++++++++
 tb/tb_minihls_kernel_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/minihls_arb_pkg.sv
// Shared types and defaults for the minihls kernel arbiter.
// Holds the FSM encoding, default sizing, and the index-width helper.
package minihls_arb_pkg;

  localparam int N_REQ_DEF   = 4;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 256;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RESP,
    DRAIN
  } arb_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/minihls_rr_pick.sv
// Round-robin selector: first set req bit at or above rr_ptr, wrapping at N_REQ.
// Latency: combinational.
// Backpressure: none; the result is sampled by the arbiter in IDLE only.
module minihls_rr_pick
  import minihls_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IDX_W = idx_w(N_REQ_DEF)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // One spare bit so rr_ptr + i never overflows before the wrap compare.
  localparam logic [IDX_W:0] LAST = (IDX_W+1)'(N_REQ - 1);
  localparam logic [IDX_W:0] SPAN = (IDX_W+1)'(N_REQ);

  logic [IDX_W:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (cand > LAST) begin
        cand = cand - SPAN;
      end
      if (!found && req[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/minihls_kernel_arbiter.sv
// Shares one minihls kernel among N_REQ requesters, round-robin; MINIHLS_ARB_TIMEOUT_EN adds a WAIT watchdog.
// Latency: 1 cycle req->launch, kernel schedule length launch->capture, >=5 cycles per job.
// Backpressure: result held on resp_valid until the owner's resp_accept; no launch while k_valid is stale.
module minihls_kernel_arbiter
  import minihls_arb_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  output logic [N_REQ-1:0]  grant,
  output logic [N_REQ-1:0]  resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  input  logic [N_REQ-1:0]  resp_accept,
  output logic              k_ready,
  output logic              k_accept,
  input  logic              k_valid,
  input  logic [DATA_W-1:0] k_out,
  output logic              busy
);

  localparam int               IDX_W    = idx_w(N_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  arb_state_t        state, state_nxt;
  logic [IDX_W-1:0]  rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0]  owner, owner_nxt;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;
  logic [N_REQ-1:0]  owner_oh;
  logic [DATA_W-1:0] resp_data_nxt;
  logic              k_accept_nxt;
  logic              tmo_hit;
  logic              drain_ack;

  minihls_rr_pick #(
    .N_REQ(N_REQ),
    .IDX_W(IDX_W)
  ) u_pick (
    .req   (req),
    .rr_ptr(rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef MINIHLS_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT) + 1;

  logic [TMO_W-1:0] tmo_cnt;
  logic             drain_acked;

  assign tmo_hit   = (state == WAIT) && !k_valid && (tmo_cnt == TMO_W'(TIMEOUT - 1));
  // A result that outlived its timeout is acked once in DRAIN and dropped.
  assign drain_ack = (state == DRAIN) && resp_err && k_valid && !drain_acked;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt     <= '0;
      resp_err    <= 1'b0;
      drain_acked <= 1'b0;
    end else begin
      tmo_cnt <= (state == WAIT) ? tmo_cnt + 1'b1 : '0;
      if (tmo_hit) begin
        resp_err <= 1'b1;
      end else if (state_nxt == IDLE) begin
        resp_err <= 1'b0;
      end
      if (drain_ack) begin
        drain_acked <= 1'b1;
      end else if (state_nxt == IDLE) begin
        drain_acked <= 1'b0;
      end
    end
  end
`else
  logic unused_tmo;

  assign tmo_hit    = 1'b0;
  assign drain_ack  = 1'b0;
  assign resp_err   = 1'b0;
  assign unused_tmo = ^TIMEOUT;
`endif

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    rr_ptr_nxt    = rr_ptr;
    resp_data_nxt = resp_data;
    k_accept_nxt  = drain_ack;
    owner_oh      = '0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          owner_nxt = pick_idx;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        if (k_valid) begin
          resp_data_nxt = k_out;
          k_accept_nxt  = 1'b1;
          state_nxt     = RESP;
        end else if (tmo_hit) begin
          resp_data_nxt = '0;
          state_nxt     = RESP;
        end
      end
      RESP: begin
        if (resp_accept[owner]) begin
          rr_ptr_nxt = (owner == LAST_IDX) ? '0 : owner + 1'b1;
          state_nxt  = DRAIN;
        end
      end
      DRAIN: begin
        if (!k_valid) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    owner_oh[owner_nxt] = 1'b1;
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      resp_data  <= '0;
      k_accept   <= 1'b0;
      k_ready    <= 1'b0;
      grant      <= '0;
      resp_valid <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      rr_ptr     <= rr_ptr_nxt;
      owner      <= owner_nxt;
      resp_data  <= resp_data_nxt;
      k_accept   <= k_accept_nxt;
      k_ready    <= (state_nxt == LAUNCH);
      grant      <= (state_nxt == LAUNCH) ? owner_oh : '0;
      resp_valid <= (state_nxt == RESP) ? owner_oh : '0;
      busy       <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_minihls_kernel_arbiter.sv
// Directed bench for minihls_kernel_arbiter with a behavioural kernel of programmable latency.
module tb_minihls_kernel_arbiter;

  localparam int NR  = 4;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NR-1:0] req, grant, resp_valid, resp_accept;
  logic [DW-1:0] resp_data, k_out;
  logic          resp_err, k_ready, k_accept, k_valid, busy;

  int n_chk = 0, n_pass = 0;
  int n_kacc = 0, n_kready = 0, n_grant = 0, n_overlap = 0, cyc = 0;
  int gcyc[$];

  int          kst, kcnt, kern_lat;
  bit          kern_late;
  logic [DW-1:0] kern_val;

  always #5 clk = ~clk;

  minihls_kernel_arbiter #(
    .N_REQ  (NR),
    .DATA_W (DW),
    .TIMEOUT(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .grant      (grant),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .resp_accept(resp_accept),
    .k_ready    (k_ready),
    .k_accept   (k_accept),
    .k_valid    (k_valid),
    .k_out      (k_out),
    .busy       (busy)
  );

  // Kernel: starts on k_ready, valid after kern_lat cycles, holds until k_accept.
  // kern_late keeps valid one extra cycle with a corrupted value.
  assign k_out = (kst == 3) ? ~kern_val : kern_val;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      kst     <= 0;
      kcnt    <= 0;
      k_valid <= 1'b0;
    end else begin
      case (kst)
        0: if (k_ready) begin
             if (kern_lat <= 1) begin k_valid <= 1'b1; kst <= 2; end
             else begin kcnt <= kern_lat - 1; kst <= 1; end
           end
        1: if (kcnt == 1) begin k_valid <= 1'b1; kst <= 2; end
           else kcnt <= kcnt - 1;
        2: if (k_accept) begin
             if (kern_late) kst <= 3;
             else begin k_valid <= 1'b0; kst <= 0; end
           end
        default: begin k_valid <= 1'b0; kst <= 0; end
      endcase
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      if (k_accept) n_kacc++;
      if (k_ready) n_kready++;
      if (grant != '0) begin n_grant++; gcyc.push_back(cyc); end
      if (k_ready && k_valid) n_overlap++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic int oh_idx(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic wait_grant(output int g);
    g = -1;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (grant != '0) begin g = oh_idx(grant); break; end
    end
  endtask

  task automatic wait_resp(output int n);
    n = 999;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (resp_valid != '0) begin n = t + 1; break; end
    end
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (!busy) break;
    end
  endtask

  task automatic accept();
    resp_accept = resp_valid;
    @(negedge clk);
    resp_accept = '0;
  endtask

  task automatic serve_one(input int exp_g, input logic [DW-1:0] exp_d, input bit drop,
                           input string tag);
    int g, n;
    logic [NR-1:0] oh;
    oh = '0;
    oh[exp_g] = 1'b1;
    wait_grant(g);
    chk({tag, "_grant"}, g, exp_g);
    if (drop) req = '0;
    wait_resp(n);
    chk({tag, "_rvld"}, resp_valid, oh);
    chk({tag, "_rdata"}, resp_data, exp_d);
    chk({tag, "_rerr"}, resp_err, 0);
    accept();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g, n, kacc0;
    req = '0; resp_accept = '0;
    kern_lat = 1; kern_late = 0; kern_val = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_rvld", resp_valid, 0);
    chk("rst_ctl", {busy, k_ready, k_accept, resp_err}, 0);
    chk("rst_rdata", resp_data, 0);
    rst = 1'b0;

    // Single requester, 5-cycle kernel; owner drops req after grant.
    kern_lat = 5; kern_val = 32'd7; req = 4'b0100;
    wait_grant(g);
    chk("t1_grant", g, 2);
    chk("t1_kready", k_ready, 1);
    chk("t1_busy", busy, 1);
    req = '0; kacc0 = n_kacc;
    @(negedge clk);
    chk("t1_kready_off", k_ready, 0);
    chk("t1_grant_off", grant, 0);
    wait_resp(n);
    chk("t1_lat", n, 5);
    chk("t1_rvld", resp_valid, 4'b0100);
    chk("t1_rdata", resp_data, 7);
    chk("t1_rerr", resp_err, 0);
    repeat (2) @(negedge clk);
    chk("t1_hold", resp_valid, 4'b0100);
    accept();
    chk("t1_rvld_off", resp_valid, 0);
    wait_idle();
    chk("t1_idle", busy, 0);
    chk("t1_kacc", n_kacc - kacc0, 1);
    // rr_ptr is now 3, so 3 wins over 0.
    req = 4'b1001;
    serve_one(3, 32'd7, 1, "t1_ptr");
    wait_idle();

    // All requesters held: strict rotation at 5 cycles per job.
    kern_lat = 1; kern_val = 32'h11; gcyc.delete(); req = 4'hF;
    for (int j = 0; j < 8; j++) serve_one(j % 4, 32'h11, 0, "t2");
    req = '0;
    wait_idle();
    chk("t2_idle", busy, 0);
    chk("t2_njobs", gcyc.size(), 8);
    for (int j = 1; j < 8; j++) chk("t2_gap", gcyc[j] - gcyc[j-1], 5);

    // Stale k_valid after accept delays the next launch and is not captured.
    kern_late = 1; kern_val = 32'hA5; gcyc.delete(); kacc0 = n_kacc; req = 4'b0011;
    wait_grant(g);
    chk("t3_grant0", g, 0);
    req = 4'b0010;
    wait_resp(n);
    chk("t3_rdata0", resp_data, 32'hA5);
    accept();
    chk("t3_no_recap", resp_data, 32'hA5);
    chk("t3_drain_busy", busy, 1);
    kern_val = 32'h5A;
    serve_one(1, 32'h5A, 1, "t3b");
    wait_idle();
    chk("t3_gap", gcyc[1] - gcyc[0], 6);
    chk("t3_kacc", n_kacc - kacc0, 2);
    chk("t3_overlap", n_overlap, 0);
    kern_late = 0;

    // Async reset mid-WAIT clears outputs without a clock edge and restarts rr_ptr.
    kern_lat = 10; kern_val = 32'hBEEF; req = 4'b0100;
    wait_grant(g);
    chk("t4_grant", g, 2);
    req = '0;
    repeat (2) @(negedge clk);
    chk("t4_busy_pre", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("t4_rst_ctl", {busy, k_ready, k_accept, resp_err}, 0);
    chk("t4_rst_vec", {grant, resp_valid}, 0);
    chk("t4_rst_rdata", resp_data, 0);
    @(negedge clk);
    rst = 1'b0;
    kern_lat = 1; kern_val = 32'h33; req = 4'b1010;
    serve_one(1, 32'h33, 1, "t4a");
    req = 4'b1000;
    serve_one(3, 32'h33, 1, "t4b");
    wait_idle();

    // Non-owner accept is ignored.
    kern_lat = 2; kern_val = 32'h1234; req = 4'b0100;
    wait_grant(g);
    chk("t5_grant", g, 2);
    req = '0;
    wait_resp(n);
    chk("t5_rvld", resp_valid, 4'b0100);
    resp_accept = 4'b0001;
    repeat (3) @(negedge clk);
    chk("t5_hold_vld", resp_valid, 4'b0100);
    chk("t5_hold_data", resp_data, 32'h1234);
    resp_accept = '0;
    accept();
    chk("t5_rvld_off", resp_valid, 0);
    wait_idle();
    chk("t5_idle", busy, 0);

`ifdef MINIHLS_ARB_TIMEOUT_EN
    // Kernel slower than the watchdog: error response, then one ack for the late result.
    kern_lat = 20; kern_val = 32'hDEAD; kacc0 = n_kacc; req = 4'b0001;
    wait_grant(g);
    chk("to_grant", g, 0);
    req = '0;
    wait_resp(n);
    chk("to_lat", n, 17);
    chk("to_rvld", resp_valid, 4'b0001);
    chk("to_rerr", resp_err, 1);
    chk("to_rdata", resp_data, 0);
    chk("to_no_kacc", n_kacc - kacc0, 0);
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      if (k_valid) break;
    end
    @(negedge clk);
    chk("to_resp_ignores_kvld", n_kacc - kacc0, 0);
    chk("to_resp_no_capture", resp_data, 0);
    accept();
    wait_idle();
    chk("to_idle", busy, 0);
    chk("to_late_kacc", n_kacc - kacc0, 1);
    chk("to_rerr_clr", resp_err, 0);
    chk("to_discard", resp_data, 0);
`endif

    chk("kready_eq_grant", n_kready, n_grant);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
